data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the EX/MEM data-memory request interface. It accepts the MEM-stage request fields (enable, read/write, size, sign-extend, address, store data) and serves them from a byte-addressed, big-endian data memory with a fixed multi-cycle latency. While an access is in flight it stalls the pipeline, then returns aligned and extended load data together with a one-cycle completion pulse.

## Interface
- `DEPTH`, 1024: memory size in bytes; power of two; address bits above log2(DEPTH) are ignored.
- `LAT`, 2: access latency in cycles, at least 1.
- `clk` input 1: clock, rising edge.
- `R` input 1: reset. One clock; reset is synchronous and active-high.
- `E` input 1: request enable, from `E_mem`.
- `rw_dm` input 1: 0 = load, 1 = store.
- `size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `se` input 1: sign-extend load data (byte and halfword only).
- `addr` input 32: byte address, from `alu_out_mem`.
- `wdata` input 32: store data, from `df_a_mem`; the low byte, low half or full word is written.
- `rdata` output 32: registered load result.
- `stall` output 1: combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: misalignment flag, valid while `done` is high.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - If `E`=1, the block captures `rw_dm`, `size`, `se`, `addr` and `wdata` into internal registers.
  - It loads counter `cnt` with LAT-1 and goes to BUSY.
- **BUSY:**
  - If `cnt`≠0, it decrements `cnt`.
  - If `cnt`=0, it performs the access using the captured fields and goes to DONE.
- **DONE:** `done`=1 for this cycle only, then the FSM returns to IDLE unconditionally.
  - The pipeline advances at the end of the DONE cycle.
  - A new request seen in the following IDLE cycle is accepted normally.
- `stall` = (IDLE and `E`) or BUSY. It is 0 in DONE.
- **Big-endian addressing:** `addr` holds the MSB.
  - Halfword = {mem[a], mem[a+1]}.
  - Word = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- **Loads:**
  - `rdata` is zero-extended, or sign-extended from bit 7 (byte) or bit 15 (halfword) when `se`=1.
  - For word loads `se` is ignored.
- **Stores:** write `size` bytes of `wdata`, taken LSB-aligned, and leave `rdata` unchanged.
- **Address wrap:** the index is `addr` mod DEPTH. Multi-byte accesses never cross DEPTH because they are aligned.
- **Memory contents:** all bytes are zero at simulation start, and `R` does not clear them.

## Timing
- **Reset values:** state IDLE, `cnt`=0, `rdata`=0, `done`=0, `err`=0. `stall`=0 in the same cycle as `R` is asserted.
- **Request sequence:** a request is present in cycle t with IDLE.
  - Cycles t through t+LAT: `stall`=1.
  - Cycle t+LAT+1: DONE.
- **Commit point:** the memory write and the `rdata` update both happen on the rising edge that enters DONE.
- **Held request fields:** they are captured at acceptance, so changes on the inputs during BUSY have no effect.
- **Reset mid-operation:** the FSM returns to IDLE next cycle, and no write is committed unless the DONE edge has already occurred.
- **Back-to-back accesses:** every access costs LAT+2 cycles per request, including one IDLE sampling cycle. There is no pipelining between accesses.
- **`E`=0 in IDLE:** outputs hold, and `rdata` keeps its last value.

## Configuration
- **`DM_ALIGN_CHECK_EN` defined:**
  - A halfword with `addr`[0]≠0, or a word with `addr`[1:0]≠0, is misaligned.
  - A misaligned access sets `err`=1 in DONE; a store writes nothing and a load sets `rdata`=0.
  - Latency is unchanged.
- **Not defined:**
  - The low address bits are forced to alignment: bit 0 for halfwords, bits 1:0 for words.
  - `err` is tied to 0.

## Test plan
- **Reset:** after reset, `rdata`=0, `done`=0 and `stall`=0.
  - Assert `R` during BUSY of a store → state IDLE next cycle, and a later word load of that address returns 0.
- **Store/load word:** LAT=2; word store of 0xDEADBEEF to 0x10.
  - `stall` is high for 3 cycles and `done` pulses in the 4th.
  - A word load of 0x10 returns 0xDEADBEEF.
  - Byte loads of 0x10 and 0x13 return 0xDE and 0xEF.
- **Sign extension:** after the word store above:
  - Byte load of 0x10 with `se`=1 → 0xFFFFFFDE.
  - Halfword load of 0x12 with `se`=1 → 0xFFFFBEEF; with `se`=0 → 0x0000BEEF.
- **Partial store:** byte store of 0x12345677 to 0x11 over 0xDEADBEEF; a word load of 0x10 returns 0xDE77BEEF.
- **Alignment, with `DM_ALIGN_CHECK_EN`:** word store to 0x21 → `err`=1 with `done`, and the memory is unchanged.
  - Without the macro, the same store writes to 0x20, `err`=0, and a word load of 0x20 returns the stored data.
- **Back-to-back and wrap:** DEPTH=1024, two consecutive requests with `E` held.
  - Each request gets its own `done` pulse, LAT+2 cycles apart.
  - A word store to 0x400 then a word load of 0x0 returns the stored value.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - EX/MEM data-memory request/response bundle
interface data_memory_responder_if;
    logic        E;
    logic        rw_dm;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    // Pipeline side: issues requests, observes stall/completion
    modport master (
        output E, rw_dm, size, se, addr, wdata,
        input  rdata, stall, done, err
    );

    // Memory side: serves requests
    modport slave (
        input  E, rw_dm, size, se, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - big-endian multi-cycle data memory responder (optional DM_ALIGN_CHECK_EN)
module data_memory_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic                    clk,
    input  logic                    R,
    data_memory_responder_if.slave  dm
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            capture_en;
    logic            commit;

    logic            rw_q;
    logic [1:0]      size_q;
    logic            se_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;

    logic [7:0]      mem_q [DEPTH];

    logic [AW-1:0]   i0, i1, i2, i3;
    logic            is_half, is_word;
    logic            misaligned;
    logic [7:0]      b0, b1, b2, b3;
    logic [31:0]     load_data;

    // Address bits above the memory size are deliberately ignored.
    logic            unused_addr_hi;
    assign unused_addr_hi = &{1'b0, dm.addr[31:AW]};

    // State, countdown and captured request fields
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            se_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture_en) begin
                rw_q    <= dm.rw_dm;
                size_q  <= dm.size;
                se_q    <= dm.se;
                addr_q  <= dm.addr[AW-1:0];
                wdata_q <= dm.wdata;
            end
            if (commit && !rw_q) begin
                rdata_q <= load_data;
            end
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, single-cycle DONE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_en = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm.E) begin
                    capture_en = 1'b1;
                    cnt_d      = CW'(LAT - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte indices of the access; size 11 behaves as a word
    always_comb begin
        is_half = (size_q == 2'b01);
        is_word = size_q[1];
        i0      = addr_q;
`ifdef DM_ALIGN_CHECK_EN
        misaligned = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
        misaligned = 1'b0;
        if (is_half) begin
            i0[0] = 1'b0;
        end
        if (is_word) begin
            i0[1:0] = 2'b00;
        end
`endif
        i1 = i0 + AW'(1);
        i2 = i0 + AW'(2);
        i3 = i0 + AW'(3);
    end

    // Big-endian load assembly with optional sign extension
    always_comb begin
        b0 = mem_q[i0];
        b1 = mem_q[i1];
        b2 = mem_q[i2];
        b3 = mem_q[i3];
        if (is_word) begin
            load_data = {b0, b1, b2, b3};
        end else if (is_half) begin
            load_data = {{16{se_q & b0[7]}}, b0, b1};
        end else begin
            load_data = {{24{se_q & b0[7]}}, b0};
        end
        if (misaligned) begin
            load_data = '0;
        end
    end

    // Store commit on the edge entering DONE; a reset in that cycle cancels it
    always_ff @(posedge clk) begin
        if (commit && !R && rw_q && !misaligned) begin
            if (is_word) begin
                mem_q[i0] <= wdata_q[31:24];
                mem_q[i1] <= wdata_q[23:16];
                mem_q[i2] <= wdata_q[15:8];
                mem_q[i3] <= wdata_q[7:0];
            end else if (is_half) begin
                mem_q[i0] <= wdata_q[15:8];
                mem_q[i1] <= wdata_q[7:0];
            end else begin
                mem_q[i0] <= wdata_q[7:0];
            end
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    logic err_q;

    // Misalignment flag is raised with DONE and dropped when returning to IDLE
    always_ff @(posedge clk) begin
        if (R) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= misaligned;
        end else if (state_q == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign dm.err = err_q;
`else
    assign dm.err = 1'b0;
`endif

    assign dm.rdata = rdata_q;
    assign dm.done  = (state_q == DONE);
    assign dm.stall = !R && (((state_q == IDLE) && dm.E) || (state_q == BUSY));

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench for data_memory_responder
module tb_data_memory_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk;
    logic R;
    data_memory_responder_if dm ();

    data_memory_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk (clk),
        .R   (R),
        .dm  (dm)
    );

    int errors = 0;
    int checks = 0;

    bit [7:0]  mem_m [DEPTH];
    bit [31:0] last_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Reference model: byte array, big-endian, returns expected rdata after the access
    function automatic bit [31:0] model_access(input bit rw, input bit [1:0] sz, input bit s,
                                               input bit [31:0] a, input bit [31:0] wd,
                                               output bit mis);
        int n;
        int idx;
        bit [31:0] val;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        idx = int'(a % DEPTH);
        mis = (idx % n) != 0;
`ifdef DM_ALIGN_CHECK_EN
        if (mis) begin
            if (!rw) last_rd = 32'h0;
            return last_rd;
        end
`else
        idx = idx - (idx % n);
        mis = 1'b0;
`endif
        if (rw) begin
            for (int k = 0; k < n; k++)
                mem_m[idx + k] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
            return last_rd;
        end
        val = 0;
        for (int k = 0; k < n; k++)
            val = (val << 8) + 32'(mem_m[idx + k]);
        if (s && n < 4 && val[8 * n - 1])
            val = val | (32'hFFFF_FFFF << (8 * n));
        last_rd = val;
        return val;
    endfunction

    // One request from an IDLE cycle (called at posedge+1); inputs scrambled once accepted
    task automatic access(input bit rw, input bit [1:0] sz, input bit s, input bit [31:0] a,
                          input bit [31:0] wd, input string tag, output bit [31:0] rd);
        bit        mis;
        bit [31:0] exp;
        int        stalls;
        int        dat;
        exp = model_access(rw, sz, s, a, wd, mis);
        dm.E = 1'b1; dm.rw_dm = rw; dm.size = sz; dm.se = s; dm.addr = a; dm.wdata = wd;
        stalls = 0;
        dat = -1;
        rd = 32'h0;
        for (int c = 0; c < LAT + 8; c++) begin
            @(negedge clk);
            if (dm.done) begin
                dat = c;
                rd  = dm.rdata;
                break;
            end
            if (dm.stall) stalls++;
            @(posedge clk); #1;
            dm.E = 1'b0;
            dm.rw_dm = 1'($urandom); dm.size = 2'($urandom); dm.se = 1'($urandom);
            dm.addr = $urandom; dm.wdata = $urandom;
        end
        checks++;
        if (dat != LAT + 1) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d required %0d", tag, dat, LAT + 1);
        end
        if (dat >= 0) begin
            checks++;
            if (stalls != LAT + 1) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d required %0d", tag, stalls, LAT + 1);
            end
            checks++;
            if (dm.rdata !== exp) begin
                errors++;
                $display("FAIL %s rdata: got %h required %h", tag, dm.rdata, exp);
            end
            checks++;
            if (dm.err !== mis) begin
                errors++;
                $display("FAIL %s err: got %b required %b", tag, dm.err, mis);
            end
            checks++;
            if (dm.stall !== 1'b0) begin
                errors++;
                $display("FAIL %s stall_in_done: got %b required 0", tag, dm.stall);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_val(input string tag, input bit [31:0] got, input bit [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, req);
        end
    endtask

    task automatic test_reset();
        R = 1'b1;
        dm.E = 1'b1; dm.rw_dm = 1'b1; dm.size = 2'd2; dm.se = 1'b0;
        dm.addr = 32'h40; dm.wdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dm.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_with_E: got %b required 0", dm.stall);
        end
        checks++;
        if (dm.rdata !== 32'h0 || dm.done !== 1'b0 || dm.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h done=%b err=%b required 0/0/0",
                     dm.rdata, dm.done, dm.err);
        end
        @(posedge clk); #1;
        R = 1'b0; dm.E = 1'b0;
        @(negedge clk);
        checks++;
        if (dm.stall !== 1'b0 || dm.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got stall=%b done=%b required 0/0", dm.stall, dm.done);
        end
        last_rd = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load_word();
        bit [31:0] rd;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_10", rd);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10", rd);
        expect_val("lw_10_value", rd, 32'hDEAD_BEEF);
        access(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, "lb_10", rd);
        expect_val("lb_10_value", rd, 32'h0000_00DE);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb_13", rd);
        expect_val("lb_13_value", rd, 32'h0000_00EF);
    endtask

    task automatic test_sign_ext();
        bit [31:0] rd;
        access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, "lbs_10", rd);
        expect_val("lbs_10_value", rd, 32'hFFFF_FFDE);
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lhs_12", rd);
        expect_val("lhs_12_value", rd, 32'hFFFF_BEEF);
        access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lhu_12", rd);
        expect_val("lhu_12_value", rd, 32'h0000_BEEF);
        access(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, "lw_se_ignored", rd);
        expect_val("lw_se_ignored_value", rd, 32'hDEAD_BEEF);
    endtask

    task automatic test_partial_store();
        bit [31:0] rd;
        access(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_5677, "sb_11", rd);
        expect_val("sb_keeps_rdata", rd, 32'hDEAD_BEEF);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10_after_sb", rd);
        expect_val("lw_10_after_sb_value", rd, 32'hDE77_BEEF);
    endtask

    task automatic test_alignment();
        bit [31:0] rd;
        access(1'b1, 2'd2, 1'b0, 32'h21, 32'hA5C3_5A3C, "sw_21", rd);
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20", rd);
`ifdef DM_ALIGN_CHECK_EN
        expect_val("lw_20_unchanged", rd, 32'h0);
`else
        expect_val("lw_20_forced_align", rd, 32'hA5C3_5A3C);
`endif
    endtask

    // Reset landing in BUSY (after d cycles) must cancel the pending store
    task automatic test_reset_mid_op(input int d, input bit [31:0] a);
        bit [31:0] rd;
        dm.E = 1'b1; dm.rw_dm = 1'b1; dm.size = 2'd2; dm.se = 1'b0;
        dm.addr = a; dm.wdata = 32'hCAFE_F00D;
        repeat (d) begin
            @(posedge clk); #1;
            dm.E = 1'b0;
        end
        R = 1'b1;
        @(negedge clk);
        expect_val("rst_mid_stall_low", {31'h0, dm.stall}, 32'h0);
        @(posedge clk); #1;
        R = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        checks++;
        if (dm.stall !== 1'b0 || dm.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got stall=%b done=%b required 0/0", dm.stall, dm.done);
        end
        @(posedge clk); #1;
        access(1'b0, 2'd2, 1'b0, a, 32'h0, "lw_after_rst", rd);
        expect_val("lw_after_rst_value", rd, 32'h0);
    endtask

    task automatic test_back_to_back();
        bit        mis;
        bit [31:0] wd;
        bit [31:0] exp2;
        int        d1;
        int        d2;
        bit [31:0] rd2;
        wd = $urandom;
        void'(model_access(1'b1, 2'd2, 1'b0, 32'h400, wd, mis));
        exp2 = model_access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, mis);
        d1 = -1; d2 = -1; rd2 = 32'h0;
        dm.E = 1'b1; dm.rw_dm = 1'b1; dm.size = 2'd2; dm.se = 1'b0;
        dm.addr = 32'h400; dm.wdata = wd;
        for (int c = 0; c < 3 * (LAT + 2) + 4; c++) begin
            @(negedge clk);
            if (dm.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    dm.rw_dm = 1'b0; dm.addr = 32'h0; dm.wdata = $urandom;
                end else begin
                    d2 = c;
                    rd2 = dm.rdata;
                    dm.E = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        dm.E = 1'b0;
        expect_val("b2b_first_done", 32'(d1), 32'(LAT + 1));
        expect_val("b2b_gap", 32'(d2 - d1), 32'(LAT + 2));
        expect_val("b2b_wrap_load", rd2, exp2);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit [31:0] rd;
        bit [31:0] a;
        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
            access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rand", rd);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    checks++;
                    if (dm.rdata !== last_rd || dm.done !== 1'b0 || dm.stall !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_hold: got rdata=%h done=%b stall=%b required %h/0/0",
                                 dm.rdata, dm.done, dm.stall, last_rd);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        R = 1'b1;
        dm.E = 1'b0; dm.rw_dm = 1'b0; dm.size = 2'd0; dm.se = 1'b0;
        dm.addr = 32'h0; dm.wdata = 32'h0;
        last_rd = 32'h0;
        test_reset();
        test_store_load_word();
        test_sign_ext();
        test_partial_store();
        test_alignment();
        test_reset_mid_op(1, 32'h80);
        test_reset_mid_op(LAT, 32'h84);
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
